// File: rtl/hex_entry_buffer_if.sv
// Entry-buffer bus: raw buttons and switch nibble in, digit buffer state out.
interface hex_entry_buffer_if #(
  parameter int NUM_DIGITS = 8
) ();
  logic                    key_n;
  logic                    clr_n;
  logic [3:0]              nibble;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [3:0]              count;
  logic                    full;
  logic                    overflow;
  logic                    entry_pulse;

  modport master (
    output key_n, clr_n, nibble,
    input  digits, count, full, overflow, entry_pulse
  );

  modport slave (
    input  key_n, clr_n, nibble,
    output digits, count, full, overflow, entry_pulse
  );
endinterface

// File: rtl/hex_entry_buffer.sv
// Debounced hex-digit entry buffer: each accepted key press shifts the switch
// nibble into the low digit; a clear press empties the buffer.
module hex_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {REL, PRESS_WAIT, PRESSED, REL_WAIT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  // The counter stops at LAST, so it can never wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= REL;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        REL: begin
          if (!i_btn) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= {CW{1'b0}};
          end
        end
        PRESS_WAIT: begin
          if (i_btn) begin
            r_state <= REL;
          end else if (r_cnt == LAST) begin
            r_state <= PRESSED;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        PRESSED: begin
          if (i_btn) begin
            r_state <= REL_WAIT;
            r_cnt   <= {CW{1'b0}};
          end
        end
        REL_WAIT: begin
          if (!i_btn) begin
            r_state <= PRESSED;
          end else if (r_cnt == LAST) begin
            r_state <= REL;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= REL;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Event fires in the cycle that commits PRESS_WAIT -> PRESSED, so the
  // buffer update lands on the same edge as the state change.
  assign o_press = (r_state == PRESS_WAIT) && !i_btn && (r_cnt == LAST);
endmodule

module hex_entry_buffer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_DIGITS      = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  hex_entry_buffer_if.slave bus
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [3:0] MAX_COUNT = 4'(NUM_DIGITS);

  logic [1:0]    r_key_sync;
  logic [1:0]    r_clr_sync;
  logic [3:0]    r_nib_sync1;
  logic [3:0]    r_nib_sync2;
  logic [DW-1:0] r_digits;
  logic [3:0]    r_count;
  logic          r_overflow;
  logic          r_entry_pulse;
  logic          w_key_press;
  logic          w_clr_press;
  logic [DW-1:0] w_next_digits;

  // Synchronizers idle at the released level so reset never looks like a press.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_key_sync  <= 2'b11;
      r_clr_sync  <= 2'b11;
      r_nib_sync1 <= 4'h0;
      r_nib_sync2 <= 4'h0;
    end else begin
      r_key_sync  <= {r_key_sync[0], bus.key_n};
      r_clr_sync  <= {r_clr_sync[0], bus.clr_n};
      r_nib_sync1 <= bus.nibble;
      r_nib_sync2 <= r_nib_sync1;
    end
  end

  hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_btn   (r_key_sync[1]),
    .o_press (w_key_press)
  );

  hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_btn   (r_clr_sync[1]),
    .o_press (w_clr_press)
  );

  // Shifted buffer with the new nibble in the low digit.
  always_comb begin
    w_next_digits      = r_digits << 4;
    w_next_digits[3:0] = r_nib_sync2;
  end

  // Clear takes priority over a simultaneous key press.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_digits      <= {DW{1'b0}};
      r_count       <= 4'd0;
      r_overflow    <= 1'b0;
      r_entry_pulse <= 1'b0;
    end else begin
      r_entry_pulse <= 1'b0;
      if (w_clr_press) begin
        r_digits   <= {DW{1'b0}};
        r_count    <= 4'd0;
        r_overflow <= 1'b0;
      end else if (w_key_press) begin
        if (r_count != MAX_COUNT) begin
          r_digits      <= w_next_digits;
          r_count       <= r_count + 4'd1;
          r_entry_pulse <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign bus.digits      = r_digits;
  assign bus.count       = r_count;
  assign bus.full        = (r_count == MAX_COUNT);
  assign bus.overflow    = r_overflow;
  assign bus.entry_pulse = r_entry_pulse;
endmodule

// File: tb/tb_hex_entry_buffer.sv
// Directed bench for hex_entry_buffer with a short debounce interval.
module tb_hex_entry_buffer;
  logic CLOCK_50;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   pulses;
  int   first_edge;

  hex_entry_buffer_if #(.NUM_DIGITS(8)) bus ();

  hex_entry_buffer #(.DEBOUNCE_CYCLES(4), .NUM_DIGITS(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds the chosen buttons low for 'hold' sampling edges, then releases and
  // lets the debouncers settle, counting entry pulses along the way.
  task automatic press(input logic [3:0] nib, input int hold, input logic use_key,
                       input logic use_clr, output int n_pulse, output int edge_no);
    bus.nibble = nib;
    if (use_key) bus.key_n = 1'b0;
    if (use_clr) bus.clr_n = 1'b0;
    n_pulse = 0;
    edge_no = 0;
    for (int i = 1; i <= hold + 12; i++) begin
      if (i == hold + 1) begin
        bus.key_n = 1'b1;
        bus.clr_n = 1'b1;
      end
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (bus.entry_pulse === 1'b1) begin
        n_pulse++;
        if (edge_no == 0) edge_no = i;
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.key_n  = 1'b1;
    bus.clr_n  = 1'b1;
    bus.nibble = 4'h0;
    #1;
    check_val("rst_digits", bus.digits, 32'h0);
    check_val("rst_count", {28'h0, bus.count}, 32'd0);
    check_val("rst_full", {31'h0, bus.full}, 32'd0);
    check_val("rst_overflow", {31'h0, bus.overflow}, 32'd0);
    check_val("rst_pulse", {31'h0, bus.entry_pulse}, 32'd0);
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);

    // Single long press: one pulse at edge 7, none on release.
    press(4'hA, 12, 1'b1, 1'b0, pulses, first_edge);
    check_val("a_pulses", pulses, 32'd1);
    check_val("a_edge", first_edge, 32'd7);
    check_val("a_digits", bus.digits, 32'h0000000A);
    check_val("a_count", {28'h0, bus.count}, 32'd1);

    // Three-cycle glitch is rejected.
    press(4'h3, 3, 1'b1, 1'b0, pulses, first_edge);
    check_val("glitch_pulses", pulses, 32'd0);
    check_val("glitch_digits", bus.digits, 32'h0000000A);
    check_val("glitch_count", {28'h0, bus.count}, 32'd1);

    // Clear, then fill all eight digits.
    press(4'h0, 8, 1'b0, 1'b1, pulses, first_edge);
    check_val("clr_digits", bus.digits, 32'h0);
    check_val("clr_count", {28'h0, bus.count}, 32'd0);
    check_val("clr_pulses", pulses, 32'd0);
    for (int d = 1; d <= 8; d++) begin
      press(d[3:0], 8, 1'b1, 1'b0, pulses, first_edge);
      check_val("fill_pulse", pulses, 32'd1);
    end
    check_val("fill_digits", bus.digits, 32'h12345678);
    check_val("fill_count", {28'h0, bus.count}, 32'd8);
    check_val("fill_full", {31'h0, bus.full}, 32'd1);
    check_val("fill_overflow", {31'h0, bus.overflow}, 32'd0);

    // Ninth press overflows without changing the buffer.
    press(4'h9, 8, 1'b1, 1'b0, pulses, first_edge);
    check_val("ovf_pulses", pulses, 32'd0);
    check_val("ovf_digits", bus.digits, 32'h12345678);
    check_val("ovf_overflow", {31'h0, bus.overflow}, 32'd1);
    check_val("ovf_full", {31'h0, bus.full}, 32'd1);

    // Wiggling the switches alone changes nothing.
    for (int k = 0; k < 6; k++) begin
      bus.nibble = 4'(k * 3);
      @(negedge CLOCK_50);
    end
    check_val("nib_digits", bus.digits, 32'h12345678);
    check_val("nib_count", {28'h0, bus.count}, 32'd8);

    // Clear drops the sticky overflow.
    press(4'h0, 8, 1'b0, 1'b1, pulses, first_edge);
    check_val("clr2_overflow", {31'h0, bus.overflow}, 32'd0);
    check_val("clr2_full", {31'h0, bus.full}, 32'd0);

    // Simultaneous key and clear with three digits held: clear wins.
    for (int d = 4; d <= 6; d++) begin
      press(d[3:0], 8, 1'b1, 1'b0, pulses, first_edge);
    end
    check_val("three_digits", bus.digits, 32'h00000456);
    check_val("three_count", {28'h0, bus.count}, 32'd3);
    press(4'h7, 12, 1'b1, 1'b1, pulses, first_edge);
    check_val("both_pulses", pulses, 32'd0);
    check_val("both_digits", bus.digits, 32'h0);
    check_val("both_count", {28'h0, bus.count}, 32'd0);
    check_val("both_overflow", {31'h0, bus.overflow}, 32'd0);

    // Reset mid-press clears outputs asynchronously; held key re-debounces.
    press(4'h5, 8, 1'b1, 1'b0, pulses, first_edge);
    check_val("pre_rst_digits", bus.digits, 32'h00000005);
    bus.key_n = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_digits", bus.digits, 32'h0);
    check_val("async_count", {28'h0, bus.count}, 32'd0);
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    pulses     = 0;
    first_edge = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (bus.entry_pulse === 1'b1) begin
        pulses++;
        if (first_edge == 0) first_edge = i;
      end
    end
    bus.key_n = 1'b1;
    check_val("rel_pulses", pulses, 32'd1);
    check_val("rel_edge", first_edge, 32'd7);
    check_val("rel_digits", bus.digits, 32'h00000005);
    check_val("rel_count", {28'h0, bus.count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hex_entry_buffer.md
HEX_ENTRY_BUFFER -- requirements
Module: hex_entry_buffer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable clock cycles needed to accept a button level change (20 ms at 50 MHz). Legal range is 1 or more.
REQ-002 Parameter NUM_DIGITS, default 8, is the number of hex digits held in the buffer. Legal range is 1 to 15.
REQ-003 Port CLOCK_50: input, 1 bit, the single clock. All state updates on its rising edge.
REQ-004 Port reset: input, 1 bit, asynchronous and active-high, clears all state immediately.
REQ-005 Port key_n: input, 1 bit, raw active-low entry pushbutton, asynchronous to CLOCK_50.
REQ-006 Port clr_n: input, 1 bit, raw active-low clear pushbutton, asynchronous to CLOCK_50.
REQ-007 Port nibble: input, 4 bits, hex value from the switches that is captured on each accepted entry press.
REQ-008 Port digits: output, 4*NUM_DIGITS bits, the entered digits. Bits [3:0] hold the newest digit and feed a hex-to-7-segment decoder per nibble.
REQ-009 Port count: output, 4 bits, number of valid digits entered, 0 to NUM_DIGITS.
REQ-010 Port full: output, 1 bit, high when count equals NUM_DIGITS.
REQ-011 Port overflow: output, 1 bit, sticky; set by a press that arrives while full.
REQ-012 Port entry_pulse: output, 1 bit, high for exactly one cycle when a digit is accepted.

Function
REQ-013 key_n, clr_n and nibble shall each pass through a 2-flop synchronizer before any use.
REQ-014 Each button shall have its own debouncer FSM with states REL, PRESS_WAIT, PRESSED and REL_WAIT:
- REL to PRESS_WAIT when the synchronized input is low; the counter is cleared.
- PRESS_WAIT back to REL if the input returns high before the counter reaches DEBOUNCE_CYCLES-1.
- PRESS_WAIT to PRESSED when the counter reaches DEBOUNCE_CYCLES-1 with the input still low; this emits a one-cycle internal press event.
- PRESSED to REL_WAIT when the input goes high.
- REL_WAIT back to PRESSED if the input goes low before the count completes.
- REL_WAIT to REL when the count completes with the input still high; no event is emitted.
REQ-015 The debounce counter shall be wide enough for DEBOUNCE_CYCLES and shall never wrap.
REQ-016 A held button shall produce exactly one press event per debounced press; there is no auto-repeat.
REQ-017 On a key press event with count < NUM_DIGITS:
- digits shifts left by 4 bits and the oldest digit is discarded.
- digits[3:0] loads the synchronized nibble value from that cycle.
- count increments by 1.
- entry_pulse is high in the following cycle, registered.
REQ-018 On a key press event with count = NUM_DIGITS: digits and count are unchanged, entry_pulse stays low, and overflow is set to 1.
REQ-019 On a clear press event: digits, count and overflow go to 0 and entry_pulse stays low.
REQ-020 If clear and key press events occur in the same cycle, clear wins and the key press is discarded.
REQ-021 Latency: with key_n held low, entry_pulse rises exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples key_n low. This includes 2 synchronizer cycles and 1 output register cycle.
REQ-022 full shall be derived combinationally from the count register, so it is glitch-free relative to count.
REQ-023 Changing nibble while no press event occurs shall have no effect on any output.

Reset
REQ-024 Asserting reset shall immediately set:
- digits = 0, count = 0, full = 0, overflow = 0, entry_pulse = 0.
- Both debouncers to REL with counters at 0.
- Synchronizer flops to 1 (the released level).
REQ-025 A button still held when reset is released shall produce a press event only after a full debounce interval measured from release of reset.

Verification (DEBOUNCE_CYCLES = 4)
REQ-026 Reset pulse during activity: all outputs go to 0 asynchronously, before the next clock edge.
REQ-027 nibble = 4'hA, key_n low for 12 cycles then high:
- Single entry_pulse at edge 7.
- Then digits = 32'h0000000A, count = 1.
- No second pulse on release.
REQ-028 key_n low for 3 cycles then high (glitch): no entry_pulse, and digits and count are unchanged.
REQ-029 Nine clean presses with nibble = 1 through 9:
- After the 8th press: digits = 32'h12345678, count = 8, full = 1.
- The 9th press leaves digits unchanged, gives no pulse, and sets overflow = 1.
REQ-030 Key and clear pressed in the same cycle with count = 3: digits = 0, count = 0, overflow = 0, and no entry_pulse.
REQ-031 Reset asserted during PRESS_WAIT, key still held at reset release: entry_pulse occurs exactly 7 edges after reset release, and never before.
